simon_input_ctrl: RTL and testbench

Player-input controller for the Simon game. It sits between the four per-button debounce instances, whose one-cycle press pulses feed it, and the game sequencer FSM.
- Accepts presses only while the game has armed it.
- Rejects simultaneous presses.
- Enforces a post-press holdoff window.
- Queues accepted button codes in a small FIFO with a valid/ready handshake.
- Flags a player timeout.

---
 rtl/simon_pkg.sv | 12 +
 rtl/simon_btn_fifo.sv | 50 +++++
 rtl/simon_input_ctrl.sv | 104 ++++++++++
 tb/tb_simon_input_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared types and press-decode helpers for the Simon input controller.
package simon_pkg;
  localparam int NUM_BTN = 4;
  typedef logic [1:0] btn_code_t;
  typedef enum logic [1:0] {IDLE, LISTEN, HOLDOFF} in_state_t;
  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
  function automatic btn_code_t btn_enc(input logic [NUM_BTN-1:0] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/simon_btn_fifo.sv
// simon_btn_fifo: synchronous button-code queue; a push into a full queue is dropped even when a pop coincides.
module simon_btn_fifo
  import simon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  btn_code_t                din,
  output btn_code_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  btn_code_t mem_q [DEPTH];
  btn_code_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    wr_d  = flush ? '0 : wr_q + AW'(push_ok);
    rd_d  = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/simon_input_ctrl.sv
// simon_input_ctrl: arms/disarms player input, filters presses, queues codes, flags timeouts.
// Define SIMON_LED_ECHO_EN to add the led_echo feedback output.
module simon_input_ctrl
  import simon_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int CNT_W          = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic [NUM_BTN-1:0]            press_in,
  input  logic                          btn_ready,
  output logic                          btn_valid,
  output btn_code_t                     btn_code,
  output logic                          listening,
  output logic                          timeout,
  output logic                          multi_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SIMON_LED_ECHO_EN
  ,
  output logic [NUM_BTN-1:0]            led_echo
`endif
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  in_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, multi_err_q, multi_err_d, overflow_q, overflow_d;
  logic push, pop, full, empty, press_one;
  assign press_one = is_onehot(press_in);
  assign pop       = btn_valid && btn_ready;
  assign btn_valid = !empty;
  assign listening = state_q == LISTEN;
  assign timeout   = timeout_q;
  assign multi_err = multi_err_q;
  assign overflow  = overflow_q;
  // A one-hot press on the last timeout cycle takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    timeout_d   = 1'b0;
    multi_err_d = 1'b0;
    overflow_d  = 1'b0;
    if (disarm) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = arm ? LISTEN : IDLE;
      cnt_d   = arm ? '0 : cnt_q;
    end else if (state_q == LISTEN) begin
      multi_err_d = (press_in != '0) && !press_one;
      push        = press_one;
      overflow_d  = press_one && full;
      timeout_d   = !press_one && cnt_q == TO_LAST;
      state_d     = press_one ? HOLDOFF : timeout_d ? IDLE : LISTEN;
      cnt_d       = (press_one || timeout_d) ? '0 : cnt_q + 1'b1;
    end else begin
      state_d = cnt_q == HO_LAST ? LISTEN : HOLDOFF;
      cnt_d   = cnt_q == HO_LAST ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      multi_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      multi_err_q <= multi_err_d;
      overflow_q  <= overflow_d;
    end
  end
  simon_btn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (disarm),
    .din   (btn_enc(press_in)),
    .dout  (btn_code),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
`ifdef SIMON_LED_ECHO_EN
  logic [NUM_BTN-1:0] led_q, led_d;
  assign led_echo = led_q;
  assign led_d = state_d == HOLDOFF ? (push ? press_in : led_q) : '0;
  always_ff @(posedge clk) begin
    if (reset) led_q <= '0;
    else led_q <= led_d;
  end
`endif
endmodule

// File: tb/tb_simon_input_ctrl.sv
// tb_simon_input_ctrl: directed self-checking bench for simon_input_ctrl (FIFO_DEPTH=2, HOLDOFF=4, TIMEOUT=16).
module tb_simon_input_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0, disarm = 1'b0, btn_ready = 1'b0;
  logic [3:0] press_in = 4'b0;
  logic btn_valid, listening, timeout, multi_err, overflow;
  logic [1:0] btn_code;
  logic [1:0] fifo_count;
  int total = 0, passed = 0;
`ifdef SIMON_LED_ECHO_EN
  logic [3:0] led_echo;
`endif

  simon_input_ctrl #(
    .FIFO_DEPTH(2), .HOLDOFF_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_W(18)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .press_in(press_in),
    .btn_ready(btn_ready), .btn_valid(btn_valid), .btn_code(btn_code),
    .listening(listening), .timeout(timeout), .multi_err(multi_err),
    .overflow(overflow), .fifo_count(fifo_count)
`ifdef SIMON_LED_ECHO_EN
    , .led_echo(led_echo)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] p);
    press_in = p;
    tick();
    press_in = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if ({btn_valid, listening, timeout, multi_err, overflow} !== 5'b0) $display("FAIL reset_flags: got %b exp 00000", {btn_valid, listening, timeout, multi_err, overflow}); else passed++;
    total++; if (fifo_count !== 2'd0) $display("FAIL reset_count: got %0d exp 0", fifo_count); else passed++;
    total++; if (btn_code !== 2'd0) $display("FAIL reset_code: got %0d exp 0", btn_code); else passed++;
`ifdef SIMON_LED_ECHO_EN
    total++; if (led_echo !== 4'b0) $display("FAIL reset_led: got %b exp 0000", led_echo); else passed++;
`endif
    reset = 1'b0;
    press(4'b0001);
    total++; if (fifo_count !== 2'd0) $display("FAIL idle_ignore: got %0d exp 0", fifo_count); else passed++;
  endtask

  task automatic test_press();
    arm = 1'b1; tick(); arm = 1'b0;
    total++; if (listening !== 1'b1) $display("FAIL arm_listen: got %b exp 1", listening); else passed++;
    press(4'b0100);
    total++; if (btn_valid !== 1'b1 || btn_code !== 2'd2) $display("FAIL push_head: got valid=%b code=%0d exp valid=1 code=2", btn_valid, btn_code); else passed++;
    total++; if (fifo_count !== 2'd1) $display("FAIL push_count: got %0d exp 1", fifo_count); else passed++;
    total++; if (listening !== 1'b0) $display("FAIL holdoff_0: got %b exp 0", listening); else passed++;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (listening !== 1'b0) $display("FAIL holdoff_%0d: got %b exp 0", i, listening); else passed++;
    end
    tick();
    total++; if (listening !== 1'b1) $display("FAIL holdoff_end: got %b exp 1", listening); else passed++;
    btn_ready = 1'b1; tick(); btn_ready = 1'b0;
    total++; if (btn_valid !== 1'b0 || fifo_count !== 2'd0) $display("FAIL pop: got valid=%b count=%0d exp valid=0 count=0", btn_valid, fifo_count); else passed++;
  endtask

  task automatic test_multi();
    press(4'b0011);
    total++; if (multi_err !== 1'b1) $display("FAIL multi_pulse: got %b exp 1", multi_err); else passed++;
    total++; if (fifo_count !== 2'd0 || listening !== 1'b1) $display("FAIL multi_state: got count=%0d listen=%b exp count=0 listen=1", fifo_count, listening); else passed++;
    tick();
    total++; if (multi_err !== 1'b0) $display("FAIL multi_width: got %b exp 0", multi_err); else passed++;
    press(4'b0001);
    total++; if (fifo_count !== 2'd1 || listening !== 1'b0) $display("FAIL multi_then_push: got count=%0d listen=%b exp count=1 listen=0", fifo_count, listening); else passed++;
    press(4'b0011);
    total++; if (multi_err !== 1'b0) $display("FAIL multi_holdoff: got %b exp 0", multi_err); else passed++;
    total++; if (fifo_count !== 2'd1) $display("FAIL multi_holdoff_count: got %0d exp 1", fifo_count); else passed++;
    disarm = 1'b1; tick(); disarm = 1'b0;
    total++; if (listening !== 1'b0 || fifo_count !== 2'd0) $display("FAIL multi_disarm: got listen=%b count=%0d exp 0 0", listening, fifo_count); else passed++;
  endtask

  task automatic test_timeout();
    int early = 0, extra = 0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (timeout !== 1'b0) early++;
    end
    total++; if (early !== 0) $display("FAIL timeout_early: got %0d pulses exp 0", early); else passed++;
    tick();
    total++; if (timeout !== 1'b1 || listening !== 1'b0) $display("FAIL timeout_fire: got to=%b listen=%b exp to=1 listen=0", timeout, listening); else passed++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timeout !== 1'b0) extra++;
    end
    total++; if (extra !== 0) $display("FAIL timeout_repeat: got %0d pulses exp 0", extra); else passed++;
  endtask

  task automatic test_overflow();
    arm = 1'b1; tick(); arm = 1'b0;
    btn_ready = 1'b0;
    press(4'b0010);
    total++; if (fifo_count !== 2'd1 || btn_code !== 2'd1) $display("FAIL ovf_first: got count=%0d code=%0d exp 1 1", fifo_count, btn_code); else passed++;
    repeat (4) tick();
    press(4'b1000);
    total++; if (fifo_count !== 2'd2 || btn_code !== 2'd1) $display("FAIL ovf_second: got count=%0d code=%0d exp 2 1", fifo_count, btn_code); else passed++;
    repeat (4) tick();
    press(4'b0001);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_pulse: got %b exp 1", overflow); else passed++;
    total++; if (fifo_count !== 2'd2 || btn_code !== 2'd1 || listening !== 1'b0) $display("FAIL ovf_state: got count=%0d code=%0d listen=%b exp 2 1 0", fifo_count, btn_code, listening); else passed++;
    btn_ready = 1'b1;
    tick();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_width: got %b exp 0", overflow); else passed++;
    total++; if (btn_code !== 2'd3 || fifo_count !== 2'd1) $display("FAIL drain_1: got code=%0d count=%0d exp 3 1", btn_code, fifo_count); else passed++;
    tick();
    btn_ready = 1'b0;
    total++; if (btn_valid !== 1'b0 || fifo_count !== 2'd0) $display("FAIL drain_2: got valid=%b count=%0d exp 0 0", btn_valid, fifo_count); else passed++;
  endtask

  task automatic test_disarm_flush();
    repeat (4) tick();
    press(4'b0100);
    repeat (4) tick();
    press(4'b1000);
    repeat (4) tick();
    total++; if (fifo_count !== 2'd2 || listening !== 1'b1) $display("FAIL flush_setup: got count=%0d listen=%b exp 2 1", fifo_count, listening); else passed++;
    disarm = 1'b1; arm = 1'b1; press_in = 4'b0001;
    tick();
    disarm = 1'b0; arm = 1'b0; press_in = 4'b0;
    total++; if (listening !== 1'b0 || fifo_count !== 2'd0 || btn_valid !== 1'b0) $display("FAIL flush: got listen=%b count=%0d valid=%b exp 0 0 0", listening, fifo_count, btn_valid); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL flush_no_ovf: got %b exp 0", overflow); else passed++;
    tick();
    total++; if (listening !== 1'b0 || fifo_count !== 2'd0) $display("FAIL flush_idle: got listen=%b count=%0d exp 0 0", listening, fifo_count); else passed++;
  endtask

`ifdef SIMON_LED_ECHO_EN
  task automatic test_led_echo();
    arm = 1'b1; tick(); arm = 1'b0;
    total++; if (led_echo !== 4'b0) $display("FAIL led_idle: got %b exp 0000", led_echo); else passed++;
    press(4'b1000);
    for (int i = 0; i < 4; i++) begin
      total++; if (led_echo !== 4'b1000) $display("FAIL led_on_%0d: got %b exp 1000", i, led_echo); else passed++;
      tick();
    end
    total++; if (led_echo !== 4'b0) $display("FAIL led_off: got %b exp 0000", led_echo); else passed++;
    press(4'b0010);
    disarm = 1'b1; tick(); disarm = 1'b0;
    total++; if (led_echo !== 4'b0) $display("FAIL led_disarm: got %b exp 0000", led_echo); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_multi();
    test_timeout();
    test_overflow();
    test_disarm_flush();
`ifdef SIMON_LED_ECHO_EN
    test_led_echo();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
